control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Processor controller FSM that sits directly upstream of the 16-bit ALU.
- Owns the program counter (PC) and instruction register (IR), and fetches from instruction ROM.
- Decodes each instruction and drives the ALU select, register-file addresses/enables and data-memory address/write strobes.
- One instruction executes at a time; there is no pipelining.

Parameters:
- PC_W, 7: PC width; instruction ROM depth is 2**PC_W words.
- DADDR_W, 8: data-memory address width; taken from IR[11:4].

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- IMem_data  in  16  instruction ROM word at IMem_addr (asynchronous read).
- IMem_addr  out  PC_W  current PC.
- D_addr  out  DADDR_W  data-memory address.
- D_wr  out  1  data-memory write strobe.
- RF_s  out  1  register-file write-data select: 0 = ALU result, 1 = data-memory read data.
- RF_W_addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_addr  out  4  register-file read port A address (feeds ALU A).
- RF_Rb_addr  out  4  register-file read port B address (feeds ALU B).
- ALU_Sel  out  3  ALU operation select.
- Halted  out  1  high while the FSM is in HALT.

Behaviour:
- Reset:
  - Synchronous, active-high. At the first rising edge with Reset=1: state=INIT, PC=0, IR=0.
  - Reset overrides any in-progress instruction; a pending store or load is abandoned.
  - All outputs are a Moore decode of state and IR. In INIT every strobe is 0, all addresses are 0, ALU_Sel=0 and Halted=0.
- Instruction format: opcode=IR[15:12], Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0], daddr=IR[11:4].
- States: INIT -> FETCH -> DECODE -> {NOOP | LOAD_A -> LOAD_B | STORE | ALU_EX | HALT} -> FETCH.
- INIT: one cycle, then FETCH.
- FETCH: at the end of the cycle, IR <= IMem_data (addressed by the old PC) and PC <= PC+1. PC wraps from 2**PC_W-1 to 0 without error.
- DECODE: no strobes asserted; selects the next state from the opcode.
- Opcodes:
  - 0000 NOOP.
  - 0001 LOAD: Rd <= D[daddr].
  - 0010 STORE: D[daddr] <= R[Rd].
  - 0011 ADD (ALU_Sel=1), 0100 SUB (2), 0101 COPY (3), 0110 XOR (4), 0111 OR (5), 1000 AND (6), 1001 INC (7).
  - 1111 HALT.
  - 1010-1110 are undefined and execute as NOOP.
- LOAD_A: D_addr=daddr, D_wr=0. The data memory has a synchronous read with 1-cycle latency.
- LOAD_B: D_addr=daddr, RF_s=1, RF_W_addr=Rd, RF_W_en=1.
- STORE: D_addr=daddr, RF_Ra_addr=Rd, D_wr=1 for exactly one cycle.
- ALU_EX:
  - RF_Ra_addr=Ra, RF_Rb_addr=Rb, ALU_Sel per the opcode table, RF_s=0, RF_W_addr=Rd, RF_W_en=1 for one cycle.
  - COPY and INC ignore Rb, but Rb is still driven from IR.
- Outside ALU_EX, ALU_Sel=0. Outside the active state of each instruction, every strobe is 0.
- Cycles per instruction: NOOP/STORE/ALU = 3, LOAD = 4.
- HALT: absorbing state with Halted=1 and no strobes; PC and IR are frozen. Only Reset exits HALT.
- Rd equal to Ra or Rb is legal; the write occurs at the end of ALU_EX.

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- When defined:
  - Adds input port Step (1 bit).
  - FETCH is held (IR and PC unchanged, no strobes) until a cycle with Step=1. The FSM then leaves FETCH, loading IR and incrementing PC at that edge.
  - Step held high runs continuously.
  - Step is ignored in every state other than FETCH.
- When undefined: the Step port does not exist and FETCH always lasts one cycle.

Decomposition:
- Shared package processor_pkg:
  - opcode enum;
  - state enum (INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ALU_EX, HALT);
  - ALU select constants (ALU_ZERO=0 … ALU_INC=7);
  - field-slice localparams for the instruction format.
- One sub-module: pc_counter. It implements a PC_W-bit register with synchronous clear (Reset) and increment enable (up), wrapping at max.

Test Plan:
- Reset held 2 cycles, then released with IMem_data=16'h0000 → INIT then FETCH; PC=0→1 after FETCH; all strobes 0; NOOP takes 3 cycles; PC=2 after the second FETCH.
- Program [16'h1053 (LOAD R3<-D[5]), 16'h3124 (ADD R4=R1+R2)] → LOAD_B: D_addr=5, RF_s=1, RF_W_addr=3, RF_W_en=1. ALU_EX: ALU_Sel=1, Ra=1, Rb=2, RF_W_addr=4, RF_W_en=1, RF_s=0.
- 16'h20A7 (STORE D[10]<-R7) → D_wr high exactly one cycle with D_addr=10, RF_Ra_addr=7; RF_W_en stays 0.
- Each ALU opcode 0011–1001 with IR=opcode,4'h1,4'h2,4'h3 → ALU_Sel = 1..7 respectively in ALU_EX; ALU_Sel=0 in all other states. Opcode 1100 → behaves as NOOP.
- Fetch 16'hF000 → Halted=1 from the cycle after DECODE; PC stays frozen for 20 cycles. Reset → INIT, PC=0, Halted=0.
- Reset asserted during LOAD_A, and PC forced to 127 via 127 NOOPs → Reset: next cycle INIT, no RF_W_en pulse. Wrap: after the FETCH at PC=127, PC=0. With CU_SINGLE_STEP_EN, Step=0 holds FETCH for 5 cycles with PC unchanged.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared types and constants for the processor controller slice:
// opcode and FSM state enumerations, ALU select codes, instruction field
// positions and the opcode-to-ALU-select mapping.
package processor_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'b0000,
    OP_LOAD  = 4'b0001,
    OP_STORE = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_COPY  = 4'b0101,
    OP_XOR   = 4'b0110,
    OP_OR    = 4'b0111,
    OP_AND   = 4'b1000,
    OP_INC   = 4'b1001,
    OP_HALT  = 4'b1111
  } opcode_e;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ALU_EX = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  localparam logic [2:0] ALU_ZERO = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_COPY = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_AND  = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

  // Instruction word layout: opcode | Ra | Rb | Rd, with daddr overlaying Ra:Rb
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RA_HI = 11;
  localparam int RA_LO = 8;
  localparam int RB_HI = 7;
  localparam int RB_LO = 4;
  localparam int RD_HI = 3;
  localparam int RD_LO = 0;
  localparam int DA_HI = 11;
  localparam int DA_LO = 4;

  // ALU select for an ALU-class opcode; anything else selects ALU_ZERO
  function automatic logic [2:0] alu_sel_of(input logic [3:0] op);
    logic [2:0] sel;
    case (op)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_COPY: sel = ALU_COPY;
      OP_XOR:  sel = ALU_XOR;
      OP_OR:   sel = ALU_OR;
      OP_AND:  sel = ALU_AND;
      OP_INC:  sel = ALU_INC;
      default: sel = ALU_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Controller-side bus: instruction ROM fetch, data-memory control,
// register-file control, ALU select and halt status.
interface control_unit_if #(
  parameter int PC_W    = 7,
  parameter int DADDR_W = 8
);
  logic [15:0]        IMem_data;
  logic [PC_W-1:0]    IMem_addr;
  logic [DADDR_W-1:0] D_addr;
  logic               D_wr;
  logic               RF_s;
  logic [3:0]         RF_W_addr;
  logic               RF_W_en;
  logic [3:0]         RF_Ra_addr;
  logic [3:0]         RF_Rb_addr;
  logic [2:0]         ALU_Sel;
  logic               Halted;

  modport master (
    input  IMem_data,
    output IMem_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_Sel, Halted
  );

  modport slave (
    output IMem_data,
    input  IMem_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_Sel, Halted
  );
endinterface

// File: rtl/control_unit_pc_counter.sv
// Program counter: PC_W-bit register with synchronous clear and an
// increment enable; wraps from all-ones back to zero.
module pc_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up,
  output logic [PC_W-1:0] pc
);

  // Clear on reset, otherwise advance by one when enabled (modular wrap)
  always_ff @(posedge clk) begin
    if (rst)     pc <= '0;
    else if (up) pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle processor controller: fetches from instruction ROM, decodes,
// and drives ALU / register-file / data-memory control as a Moore decode of
// FSM state and IR. One instruction in flight at a time.
// Optional build macro CU_SINGLE_STEP_EN adds a Step input that gates
// leaving FETCH.
module control_unit
  import processor_pkg::*;
#(
  parameter int PC_W    = 7,
  parameter int DADDR_W = 8
) (
  input  logic Clk,
  input  logic Reset,
  control_unit_if.master bus
`ifdef CU_SINGLE_STEP_EN
  ,
  input  logic Step
`endif
);

  localparam logic [3:0] ST_INIT   = 4'(S_INIT);
  localparam logic [3:0] ST_FETCH  = 4'(S_FETCH);
  localparam logic [3:0] ST_DECODE = 4'(S_DECODE);
  localparam logic [3:0] ST_NOOP   = 4'(S_NOOP);
  localparam logic [3:0] ST_LOAD_A = 4'(S_LOAD_A);
  localparam logic [3:0] ST_LOAD_B = 4'(S_LOAD_B);
  localparam logic [3:0] ST_STORE  = 4'(S_STORE);
  localparam logic [3:0] ST_ALU_EX = 4'(S_ALU_EX);
  localparam logic [3:0] ST_HALT   = 4'(S_HALT);

  logic [3:0]      state;
  logic [3:0]      state_nx;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc;
  logic            fetch_go;

  logic [3:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rd;
  logic [7:0] daddr;

  assign op    = ir[OP_HI:OP_LO];
  assign ra    = ir[RA_HI:RA_LO];
  assign rb    = ir[RB_HI:RB_LO];
  assign rd    = ir[RD_HI:RD_LO];
  assign daddr = ir[DA_HI:DA_LO];

`ifdef CU_SINGLE_STEP_EN
  assign fetch_go = (state == ST_FETCH) && Step;
`else
  assign fetch_go = (state == ST_FETCH);
`endif

  pc_counter #(.PC_W(PC_W)) u_pc (
    .clk (Clk),
    .rst (Reset),
    .up  (fetch_go),
    .pc  (pc)
  );

  assign bus.IMem_addr = pc;

  // State register; reset abandons any instruction in progress
  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_INIT;
    else       state <= state_nx;
  end

  // Instruction register captures the ROM word on the edge that leaves FETCH
  always_ff @(posedge Clk) begin
    if (Reset)         ir <= '0;
    else if (fetch_go) ir <= bus.IMem_data;
  end

  // Next-state selection; undefined opcodes fall through to NOOP
  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT:   state_nx = ST_FETCH;
      ST_FETCH:  if (fetch_go) state_nx = ST_DECODE;
      ST_DECODE: begin
        case (op)
          OP_LOAD:  state_nx = ST_LOAD_A;
          OP_STORE: state_nx = ST_STORE;
          OP_ADD, OP_SUB, OP_COPY, OP_XOR,
          OP_OR, OP_AND, OP_INC: state_nx = ST_ALU_EX;
          OP_HALT:  state_nx = ST_HALT;
          default:  state_nx = ST_NOOP;
        endcase
      end
      ST_LOAD_A: state_nx = ST_LOAD_B;
      ST_NOOP, ST_LOAD_B, ST_STORE, ST_ALU_EX: state_nx = ST_FETCH;
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_INIT;
    endcase
  end

  // Moore output decode: everything idle except in an instruction's active state
  always_comb begin
    bus.D_addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.ALU_Sel    = ALU_ZERO;
    bus.Halted     = 1'b0;
    case (state)
      ST_LOAD_A: begin
        bus.D_addr = DADDR_W'(daddr);
      end
      ST_LOAD_B: begin
        bus.D_addr    = DADDR_W'(daddr);
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = rd;
        bus.RF_W_en   = 1'b1;
      end
      ST_STORE: begin
        bus.D_addr     = DADDR_W'(daddr);
        bus.D_wr       = 1'b1;
        bus.RF_Ra_addr = rd;
      end
      ST_ALU_EX: begin
        bus.RF_Ra_addr = ra;
        bus.RF_Rb_addr = rb;
        bus.ALU_Sel    = alu_sel_of(op);
        bus.RF_W_addr  = rd;
        bus.RF_W_en    = 1'b1;
      end
      ST_HALT: begin
        bus.Halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a ROM array drives IMem_data from IMem_addr, and an
// instruction-level reference model expands each ROM word into the expected
// per-cycle output vectors (PC plus every control output).
module tb_control_unit;

  logic clk;
  logic rst;
`ifdef CU_SINGLE_STEP_EN
  logic step;
`endif

  control_unit_if #(.PC_W(7), .DADDR_W(8)) bus ();

  control_unit #(.PC_W(7), .DADDR_W(8)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
`ifdef CU_SINGLE_STEP_EN
    ,
    .Step  (step)
`endif
  );

  logic [15:0] rom [128];
  assign bus.IMem_data = rom[bus.IMem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs  = 0;
  int fails = 0;
  int mpc   = 0;
  logic [33:0] exp_q [$];

  // {pc, d_addr, d_wr, rf_s, w_addr, w_en, ra, rb, alu, halted}
  function automatic logic [33:0] pk(input logic [6:0] pc, input logic [7:0] da,
                                     input logic wr, input logic rfs,
                                     input logic [3:0] wa, input logic we,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [2:0] alu, input logic h);
    return {pc, da, wr, rfs, wa, we, ra, rb, alu, h};
  endfunction

  function automatic logic [33:0] zv(input int pc);
    return pk(7'(pc), 8'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
  endfunction

  function automatic logic [33:0] obs();
    return {bus.IMem_addr, bus.D_addr, bus.D_wr, bus.RF_s, bus.RF_W_addr,
            bus.RF_W_en, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.ALU_Sel, bus.Halted};
  endfunction

  // Reference model: append the expected cycles of one instruction, starting
  // with its FETCH cycle. HALT appends 20 frozen cycles and ends there.
  function automatic void expect_instr(input logic [15:0] w);
    int op;
    logic [7:0] da;
    logic [3:0] a, b, d;
    op = int'(w[15:12]);
    da = w[11:4];
    a  = w[11:8];
    b  = w[7:4];
    d  = w[3:0];
    exp_q.push_back(zv(mpc));
    mpc = (mpc + 1) % 128;
    exp_q.push_back(zv(mpc));
    if (op == 15) begin
      for (int k = 0; k < 20; k++)
        exp_q.push_back(pk(7'(mpc), 8'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b1));
    end else if (op == 1) begin
      exp_q.push_back(pk(7'(mpc), da, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0));
      exp_q.push_back(pk(7'(mpc), da, 1'b0, 1'b1, d, 1'b1, 4'h0, 4'h0, 3'd0, 1'b0));
    end else if (op == 2) begin
      exp_q.push_back(pk(7'(mpc), da, 1'b1, 1'b0, 4'h0, 1'b0, d, 4'h0, 3'd0, 1'b0));
    end else if (op >= 3 && op <= 9) begin
      exp_q.push_back(pk(7'(mpc), 8'h0, 1'b0, 1'b0, d, 1'b1, a, b, 3'(op - 2), 1'b0));
    end else begin
      exp_q.push_back(zv(mpc));
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset for one edge; returns sampled in the INIT cycle
  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mpc = 0;
    exp_q.delete();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  task automatic test_reset();
    clear_rom();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++;
      if (obs() !== zv(0)) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: got %h, exp %h", i, obs(), zv(0));
      end
    end
    rst = 1'b0;
    mpc = 0;
    exp_q.delete();
    tick();
    expect_instr(rom[0]);
    expect_instr(rom[1]);
    exp_q.push_back(zv(2));
    for (int i = 0; i < exp_q.size(); i++) begin
      vecs++;
      if (obs() !== exp_q[i]) begin
        fails++;
        $display("FAIL reset_noop cyc%0d: got %h, exp %h", i, obs(), exp_q[i]);
      end
      if (i != exp_q.size() - 1) tick();
    end
  endtask

  task automatic test_load_add();
    clear_rom();
    rom[0] = 16'h1053;
    rom[1] = 16'h3124;
    apply_reset();
    vecs++;
    if (obs() !== zv(0)) begin
      fails++;
      $display("FAIL load_add_init: got %h, exp %h", obs(), zv(0));
    end
    tick();
    expect_instr(rom[0]);
    expect_instr(rom[1]);
    for (int i = 0; i < exp_q.size(); i++) begin
      vecs++;
      if (obs() !== exp_q[i]) begin
        fails++;
        $display("FAIL load_add cyc%0d: got %h, exp %h", i, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_store();
    clear_rom();
    rom[0] = 16'h20A7;
    rom[1] = 16'h0000;
    apply_reset();
    tick();
    expect_instr(rom[0]);
    expect_instr(rom[1]);
    for (int i = 0; i < exp_q.size(); i++) begin
      vecs++;
      if (obs() !== exp_q[i]) begin
        fails++;
        $display("FAIL store cyc%0d: got %h, exp %h", i, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_alu_ops();
    clear_rom();
    for (int op = 3; op <= 9; op++) rom[op - 3] = {4'(op), 4'h1, 4'h2, 4'h3};
    rom[7] = 16'hC123;
    for (int i = 8; i < 60; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 14));
      rom[i] = {rop, 12'($urandom)};
    end
    apply_reset();
    tick();
    for (int i = 0; i < 60; i++) expect_instr(rom[i]);
    for (int i = 0; i < exp_q.size(); i++) begin
      vecs++;
      if (obs() !== exp_q[i]) begin
        fails++;
        $display("FAIL alu_ops cyc%0d: got %h, exp %h", i, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 16'h0000;
    rom[1] = 16'hF000;
    apply_reset();
    tick();
    expect_instr(rom[0]);
    expect_instr(rom[1]);
    for (int i = 0; i < exp_q.size(); i++) begin
      vecs++;
      if (obs() !== exp_q[i]) begin
        fails++;
        $display("FAIL halt cyc%0d: got %h, exp %h", i, obs(), exp_q[i]);
      end
      tick();
    end
    apply_reset();
    vecs++;
    if (obs() !== zv(0)) begin
      fails++;
      $display("FAIL halt_exit: got %h, exp %h", obs(), zv(0));
    end
    tick();
    vecs++;
    if (obs() !== zv(0)) begin
      fails++;
      $display("FAIL halt_refetch: got %h, exp %h", obs(), zv(0));
    end
  endtask

  task automatic test_reset_mid_load();
    logic [33:0] la;
    clear_rom();
    rom[0] = 16'h1053;
    apply_reset();
    tick();
    tick();
    tick();
    la = pk(7'd1, 8'h05, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
    vecs++;
    if (obs() !== la) begin
      fails++;
      $display("FAIL mid_load_a: got %h, exp %h", obs(), la);
    end
    rst = 1'b1;
    tick();
    vecs++;
    if (obs() !== zv(0)) begin
      fails++;
      $display("FAIL mid_load_reset: got %h, exp %h", obs(), zv(0));
    end
    rst = 1'b0;
    tick();
    vecs++;
    if (obs() !== zv(0)) begin
      fails++;
      $display("FAIL mid_load_refetch: got %h, exp %h", obs(), zv(0));
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 128; i++) begin
      int r;
      r = int'($urandom_range(0, 5));
      rom[i] = {(r == 0) ? 4'h0 : 4'(9 + r), 12'($urandom)};
    end
    apply_reset();
    tick();
    for (int i = 0; i < 130; i++) expect_instr(rom[i % 128]);
    for (int i = 0; i < exp_q.size(); i++) begin
      vecs++;
      if (obs() !== exp_q[i]) begin
        fails++;
        $display("FAIL wrap cyc%0d: got %h, exp %h", i, obs(), exp_q[i]);
      end
      tick();
    end
  endtask

`ifdef CU_SINGLE_STEP_EN
  task automatic test_single_step();
    clear_rom();
    rom[0] = 16'h3124;
    apply_reset();
    step = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (obs() !== zv(0)) begin
        fails++;
        $display("FAIL step_hold cyc%0d: got %h, exp %h", i, obs(), zv(0));
      end
      tick();
    end
    step = 1'b1;
    expect_instr(rom[0]);
    for (int i = 0; i < exp_q.size(); i++) begin
      vecs++;
      if (obs() !== exp_q[i]) begin
        fails++;
        $display("FAIL step_run cyc%0d: got %h, exp %h", i, obs(), exp_q[i]);
      end
      tick();
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, exp finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
`ifdef CU_SINGLE_STEP_EN
    step = 1'b1;
`endif
    test_reset();
    test_load_add();
    test_store();
    test_alu_ops();
    test_halt();
    test_reset_mid_load();
    test_wrap();
`ifdef CU_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
